// File: rtl/dct_block_sched.sv
// Block scheduler in front of the shared 2-D DCT pipeline.
// Grants the pipeline to Y, Cb or Cr for one full block at a time, in MCU order,
// and forwards the granted source's pixels tagged with their component id.
module dct_block_sched #(
  parameter int PIX_W   = 12,
  parameter int BLK_PIX = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_420,
  input  logic [2:0]         ena_in,
  input  logic [3*PIX_W-1:0] S_in,
  output logic [2:0]         rdy_out,
  input  logic               rdy_in,
  output logic               ena_out,
  output logic [PIX_W-1:0]   S_out,
  output logic [1:0]         comp_out,
  output logic               blk_start,
  output logic               mcu_done
);

  localparam int CW = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLK_PIX - 1);

  typedef enum logic [1:0] {GRANT, STREAM, ADVANCE} state_t;

  state_t      state;
  logic [2:0]  seq;
  logic [CW-1:0] cnt;
  logic        mode_q;
  logic [1:0]  g;

  // Component granted at a given MCU position: 4:2:0 is Y,Y,Y,Y,Cb,Cr; 4:4:4 is Y,Cb,Cr.
  function automatic logic [1:0] src_of(input logic m420, input logic [2:0] s);
    if (m420) begin
      if (s < 3'd4)       src_of = 2'd0;
      else if (s == 3'd4) src_of = 2'd1;
      else                src_of = 2'd2;
    end else begin
      src_of = s[1:0];
    end
  endfunction

  logic [2:0]       last_seq;
  logic             accept;
  logic [PIX_W-1:0] pix_sel;

  assign last_seq = mode_q ? 3'd5 : 3'd2;
  // Any ena on the granted source is taken in STREAM, even with rdy_in low:
  // that covers the single pixel already in flight when the DCT drops ready.
  assign accept   = (state == STREAM) && ena_in[g];

  // Pixel mux for the granted source.
  always_comb begin
    pix_sel = S_in[PIX_W-1:0];
    case (g)
      2'd1:    pix_sel = S_in[2*PIX_W-1:PIX_W];
      2'd2:    pix_sel = S_in[3*PIX_W-1:2*PIX_W];
      default: pix_sel = S_in[PIX_W-1:0];
    endcase
  end

  // Ready follows the DCT's ready, but only toward the granted source while streaming.
  assign rdy_out = (state == STREAM) ? (3'({2'b00, rdy_in}) << g) : 3'b000;

  // Scheduler FSM plus the one-stage registered output pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GRANT;
      seq       <= 3'd0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      g         <= 2'd0;
      ena_out   <= 1'b0;
      S_out     <= '0;
      comp_out  <= 2'd0;
      blk_start <= 1'b0;
      mcu_done  <= 1'b0;
    end else begin
      ena_out   <= 1'b0;
      blk_start <= 1'b0;
      mcu_done  <= 1'b0;
      case (state)
        GRANT: begin
          // Mode is only sampled at the head of an MCU so a mid-MCU change cannot split it.
          if (seq == 3'd0) begin
            mode_q <= mode_420;
            g      <= src_of(mode_420, seq);
          end else begin
            g      <= src_of(mode_q, seq);
          end
          state <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            ena_out   <= 1'b1;
            S_out     <= pix_sel;
            comp_out  <= g;
            blk_start <= (cnt == '0);
            mcu_done  <= (cnt == CNT_LAST) && (seq == last_seq);
            cnt       <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= ADVANCE;
          end
        end
        ADVANCE: begin
          seq   <= (seq == last_seq) ? 3'd0 : seq + 3'd1;
          state <= GRANT;
        end
        default: state <= GRANT;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_block_sched.sv
// Bench for dct_block_sched: a block-level behavioural model (schedule list,
// pixel count, bubble countdown) checked against the DUT every cycle, plus
// directed scenarios with literal expectations on block order and MCU length.
module tb_dct_block_sched;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode_420 = 1'b0;
  logic [2:0]    ena_in = 3'b000;
  logic [3*PW-1:0] S_in = '0;
  logic [2:0]    rdy_out;
  logic          rdy_in = 1'b0;
  logic          ena_out;
  logic [PW-1:0] S_out;
  logic [1:0]    comp_out;
  logic          blk_start;
  logic          mcu_done;

  dct_block_sched #(.PIX_W(PW), .BLK_PIX(64)) dut (
    .clk(clk), .rst(rst), .mode_420(mode_420), .ena_in(ena_in), .S_in(S_in),
    .rdy_out(rdy_out), .rdy_in(rdy_in), .ena_out(ena_out), .S_out(S_out),
    .comp_out(comp_out), .blk_start(blk_start), .mcu_done(mcu_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // MCU is a list of component ids; the pipeline serves list[idx] for 64 pixels,
  // then is idle for 2 cycles; after reset it is idle for 1 cycle.
  int       m_bub  = 1;
  int       m_idx  = 0;
  int       m_pix  = 0;
  bit       m_mode = 0;
  bit       e_ena = 0, e_bs = 0, e_md = 0;
  int       e_comp = 0;
  logic [PW-1:0] e_S = '0;

  function automatic int comp_of(input bit m, input int idx);
    if (m) return (idx < 4) ? 0 : idx - 3;
    return idx;
  endfunction

  function automatic int mcu_len(input bit m);
    return m ? 6 : 3;
  endfunction

  task automatic model_step();
    int gg;
    if (rst) begin
      m_bub = 1; m_idx = 0; m_pix = 0; m_mode = 0;
      e_ena = 0; e_bs = 0; e_md = 0; e_comp = 0; e_S = '0;
      return;
    end
    e_ena = 0; e_bs = 0; e_md = 0;
    if (m_bub > 0) begin
      if (m_bub == 1 && m_idx == 0) m_mode = mode_420;
      m_bub--;
    end else begin
      gg = comp_of(m_mode, m_idx);
      if (ena_in[gg]) begin
        e_ena  = 1;
        e_S    = S_in[gg*PW +: PW];
        e_comp = gg;
        e_bs   = (m_pix == 0);
        e_md   = (m_pix == 63) && (m_idx == mcu_len(m_mode) - 1);
        m_pix++;
        if (m_pix == 64) begin
          m_pix = 0;
          m_bub = 2;
          m_idx = (m_idx == mcu_len(m_mode) - 1) ? 0 : m_idx + 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare + monitor ----------------
  int n_out = 0, n_blk = 0, n_mcu = 0, mcu_at = 0;
  int n_comp[3];
  int comps[$];

  task automatic clr_mon();
    n_out = 0; n_blk = 0; n_mcu = 0; mcu_at = 0;
    n_comp[0] = 0; n_comp[1] = 0; n_comp[2] = 0;
    comps.delete();
  endtask

  initial forever begin
    logic [2:0] e_rdy;
    @(negedge clk);
    e_rdy = (m_bub == 0) ? 3'(({2'b00, rdy_in}) << comp_of(m_mode, m_idx)) : 3'b000;
    chk("rdy_out",   32'(rdy_out),   32'(e_rdy));
    chk("ena_out",   32'(ena_out),   32'(e_ena));
    chk("S_out",     32'(S_out),     32'(e_S));
    chk("comp_out",  32'(comp_out),  32'(e_comp));
    chk("blk_start", 32'(blk_start), 32'(e_bs));
    chk("mcu_done",  32'(mcu_done),  32'(e_md));
    if (ena_out) begin
      n_out++;
      if (comp_out < 3) n_comp[comp_out]++;
      if (blk_start) begin n_blk++; comps.push_back(int'(comp_out)); end
      if (mcu_done) begin n_mcu++; mcu_at = n_out; end
    end
  end

  // ---------------- stimulus ----------------
  int  cyc = 0;
  bit  rand_mode = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) S_in = {12'($urandom), 12'($urandom), 12'($urandom)};
    else           S_in = {12'(cyc + 2048), 12'(cyc + 1024), 12'(cyc)};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    clr_mon();
  endtask

  task automatic wait_mcu(input int target, input int budget, input string nm);
    int k = 0;
    while (n_mcu < target && k < budget) begin step(); k++; end
    if (n_mcu < target) chk({nm, "_timeout"}, 32'(n_mcu), 32'(target));
  endtask

  task automatic wait_out(input int target, input int budget, input string nm);
    int k = 0;
    while (n_out < target && k < budget) begin step(); k++; end
    if (n_out < target) chk({nm, "_timeout"}, 32'(n_out), 32'(target));
  endtask

  task automatic chk_order(input string nm, input int exp[$]);
    chk({nm, "_nblk"}, 32'(comps.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < comps.size(); i++)
      chk({nm, "_comp"}, 32'(comps[i]), 32'(exp[i]));
  endtask

  initial begin
    int o420[$]  = '{0, 0, 0, 0, 1, 2};
    int o444[$]  = '{0, 1, 2};
    int omix[$]  = '{0, 0, 0, 0, 1, 2, 0, 1, 2};
    clr_mon();
    // reset state
    step(); step(); step();
    @(negedge clk);
    chk("rst_rdy_out", 32'(rdy_out), 32'd0);
    chk("rst_ena_out", 32'(ena_out), 32'd0);
    chk("rst_S_out",   32'(S_out),   32'd0);
    chk("rst_comp",    32'(comp_out), 32'd0);
    chk("rst_markers", 32'({blk_start, mcu_done}), 32'd0);

    // 4:2:0 streaming, all sources valid (Cr rogue while Y granted)
    rst = 1'b0; clr_mon();
    mode_420 = 1'b1; rdy_in = 1'b1; ena_in = 3'b111;
    wait_mcu(1, 700, "s420");
    chk("s420_mcu_at", 32'(mcu_at), 32'd384);
    chk_order("s420", o420);

    // 4:4:4
    mode_420 = 1'b0;
    do_reset();
    wait_mcu(1, 400, "s444");
    chk("s444_mcu_at", 32'(mcu_at), 32'd192);
    chk_order("s444", o444);

    // mode toggled during the Cb block of a 4:2:0 MCU
    mode_420 = 1'b1;
    do_reset();
    while (n_blk < 5 && cyc < 20000) step();
    mode_420 = 1'b0;
    wait_mcu(2, 1000, "mix");
    chk("mix_mcu_at", 32'(mcu_at), 32'd576);
    chk_order("mix", omix);

    // back-pressure at pixel 20 of the Cb block with one in-flight ena
    mode_420 = 1'b1;
    do_reset();
    wait_out(4*64 + 20, 1000, "bp");
    rdy_in = 1'b0;
    step();
    ena_in = 3'b000;
    repeat (9) step();
    rdy_in = 1'b1; ena_in = 3'b111;
    wait_mcu(1, 700, "bp");
    chk("bp_mcu_at", 32'(mcu_at), 32'd384);
    chk("bp_cb_cnt", 32'(n_comp[1]), 32'd64);
    chk_order("bp", o420);

    // reset at pixel 30 of the 2nd Y block
    do_reset();
    wait_out(64 + 30, 400, "rm");
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rm_ena_out", 32'(ena_out), 32'd0);
    chk("rm_S_out",   32'(S_out),   32'd0);
    clr_mon();
    wait_mcu(1, 700, "rm");
    chk("rm_mcu_at", 32'(mcu_at), 32'd384);
    chk_order("rm", o420);

    // randomized traffic against the model
    rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      ena_in = 3'($urandom);
      rdy_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) mode_420 = ~mode_420;
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dct_block_sched.md
Name: dct_block_sched

Overview:
- Shares the single 2-D DCT pipeline between the three colour-component block sources (Y, Cb, Cr).
- Grants the pipeline to one source for exactly one 8x8 block (64 pixels) at a time, in fixed MCU order.
- Forwards that source's pixels, tagged with their component id, to the first 1-D DCT stage.
- Emits block-start and MCU-done markers for the downstream quantiser and entropy coder.

Parameters:
- PIX_W, 12, pixel/sample width.
- BLK_PIX, 64, pixels per block; must be a power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mode_420  in  1  1 = 4:2:0 MCU (Y,Y,Y,Y,Cb,Cr); 0 = 4:4:4 MCU (Y,Cb,Cr).
- ena_in  in  3  per-source pixel valid; bit0 = Y, bit1 = Cb, bit2 = Cr.
- S_in  in  3*PIX_W  packed source pixels; [PIX_W-1:0] = Y, next = Cb, top = Cr.
- rdy_out  out  3  per-source ready.
- rdy_in  in  1  DCT stage can accept a pixel.
- ena_out  out  1  pixel valid to DCT.
- S_out  out  PIX_W  pixel to DCT.
- comp_out  out  2  component of S_out: 0 = Y, 1 = Cb, 2 = Cr.
- blk_start  out  1  pulse with the first ena_out of each block.
- mcu_done  out  1  pulse with the last ena_out of the last block of an MCU.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- State: FSM states GRANT, STREAM, ADVANCE. Also holds a sequence index seq (0..5), pixel counter cnt (log2(BLK_PIX) bits) and latched mode reg mode_q.
- Reset values:
  - state = GRANT, seq = 0, cnt = 0, mode_q = 0.
  - All outputs 0: rdy_out = 000, ena_out = 0, S_out = 0, comp_out = 0, blk_start = 0, mcu_done = 0.
- Schedule:
  - 4:2:0: seq 0-3 -> Y, 4 -> Cb, 5 -> Cr.
  - 4:4:4: seq 0 -> Y, 1 -> Cb, 2 -> Cr.
  - Last seq index: 5 (4:2:0) or 2 (4:4:4).
- GRANT (1 cycle):
  - If seq == 0, latch mode_q <= mode_420. mode_420 changes mid-MCU are ignored until the next MCU.
  - Decode the granted source g from seq and mode_q; go to STREAM.
- STREAM:
  - rdy_out[g] = rdy_in; the other rdy_out bits are 0.
  - A pixel is accepted when ena_in[g] is high. Sources assert ena only after seeing rdy high; an ena arriving while rdy_in is low is still accepted (one in-flight pixel). The DCT absorbs it.
  - ena_in on a non-granted source is ignored and not forwarded; no state change.
- Output pipeline: 1-cycle registered latency. On an accept:
  - Next cycle ena_out = 1, S_out = S_in[g], comp_out = comp(g).
  - blk_start = (cnt was 0).
  - mcu_done = (cnt was BLK_PIX-1 and seq was last).
  - Otherwise ena_out, blk_start and mcu_done are 0; S_out and comp_out hold.
- Block end: when the BLK_PIX-th pixel is accepted, rdy_out drops to 000 from the next cycle, cnt wraps to 0, and the FSM goes to ADVANCE.
- ADVANCE (1 cycle): seq <= (seq == last) ? 0 : seq+1; go to GRANT.
  - Inter-block bubble is 2 cycles of rdy_out = 000.
  - A source's ena_in during the bubble is ignored.
- Simultaneous: ena_in on all three sources in the same cycle: only the granted bit is taken.
- Reset mid-block: pixels already accepted are discarded. The schedule restarts at seq 0 (Y). The partial block is not completed and no markers are emitted.
- Back-pressure: rdy_in low for any length stalls the block. cnt holds and nothing is lost beyond the one in-flight rule above.

Test Plan:
- 4:2:0 streaming: mode_420 = 1; all sources always valid with pixel value = 64*blk + index; rdy_in = 1.
  - Expect comp_out sequence 0,0,0,0,1,2 per block.
  - Expect 64 contiguous ena_out per block and a 2-cycle gap between blocks.
  - Expect blk_start on pixels 0, 64, ... and mcu_done only on the 384th pixel.
- 4:4:4 mode and mode change: mode_420 = 0 gives 3 blocks per MCU (Y,Cb,Cr), with mcu_done on the 192nd pixel.
  - Toggle mode_420 during the Cb block: the current MCU completes unchanged and the new mode applies from the next Y block.
- Back-pressure: rdy_in low for 10 cycles at pixel 20 of a Cb block, with one in-flight ena during the drop.
  - Expect the in-flight pixel forwarded, then no further accepts.
  - Expect exactly 64 Cb pixels in order with no duplicates.
- Rogue sources: Cr asserts ena_in continuously while Y is granted.
  - Expect rdy_out = 001 and only Y data on S_out.
  - Expect Cr data to appear only after the 4th Y block (4:2:0) and the Cb block.
- Reset mid-operation: rst pulsed at pixel 30 of the 2nd Y block.
  - Expect all outputs 0 the next cycle.
  - Expect the next granted block to be Y at seq 0 with blk_start on its first pixel.
  - Expect mcu_done only after a full fresh MCU.
